// File: rtl/serving_ram_arb.sv
// serving_ram_arb
//   Shares one byte-wide, 1-cycle registered-read SRAM between the CPU
//   instruction bus and data bus. Each 32-bit Wishbone-classic access is
//   arbitrated in IDLE, run as four byte accesses in RUN, and acked for one
//   cycle in ACK. Read bytes are assembled little-endian into a word.
//
//   Ports
//     i_clk, i_rst          clock, synchronous active-high reset
//     i_ibus_*/o_ibus_*     instruction bus (read only): adr, cyc / rdt, ack
//     i_dbus_*/o_dbus_*     data bus: adr, dat, sel, we, cyc / rdt, ack
//     o_ram_w*              RAM byte write port: waddr, wdata, wen
//     o_ram_r*, i_ram_rdata RAM byte read port: raddr, ren / rdata (+1 cycle)
//
//   Build option
//     SERVING_RAM_ARB_RR_EN  round-robin on simultaneous requests
//                            (undefined: dbus has fixed priority)
module serving_ram_arb #(
   parameter int depth = 256,
   parameter int aw    = $clog2(depth)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [aw-3:0] i_ibus_adr,
   input  logic          i_ibus_cyc,
   output logic [31:0]   o_ibus_rdt,
   output logic          o_ibus_ack,
   input  logic [aw-3:0] i_dbus_adr,
   input  logic [31:0]   i_dbus_dat,
   input  logic [3:0]    i_dbus_sel,
   input  logic          i_dbus_we,
   input  logic          i_dbus_cyc,
   output logic [31:0]   o_dbus_rdt,
   output logic          o_dbus_ack,
   output logic [aw-1:0] o_ram_waddr,
   output logic [7:0]    o_ram_wdata,
   output logic          o_ram_wen,
   output logic [aw-1:0] o_ram_raddr,
   output logic          o_ram_ren,
   input  logic [7:0]    i_ram_rdata
);

   typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

   // Request latched at grant; RUN only looks at this copy.
   typedef struct packed {
      logic [aw-3:0] adr;
      logic          we;
      logic [31:0]   dat;
      logic [3:0]    sel;
      logic          dbus;
   } req_t;

   state_t      state, state_nxt;
   req_t        req;
   logic [2:0]  cnt;
   logic [31:0] rdat;
   logic        any_cyc;
   logic        gnt_dbus;
   logic        run_done;
   logic [1:0]  byte_i;
   logic [1:0]  cap_i;

   assign any_cyc = i_ibus_cyc | i_dbus_cyc;
   assign byte_i  = cnt[1:0];
   // Read data lags the address by one cycle, so cnt 1..4 fills bytes 0..3.
   assign cap_i   = cnt[1:0] - 2'd1;
   // Reads need a fifth cycle to capture the last byte.
   assign run_done = req.we ? (cnt == 3'd3) : (cnt == 3'd4);

`ifdef SERVING_RAM_ARB_RR_EN
   logic last_dbus;

   // On a tie, hand the grant to whoever did not get it last time.
   assign gnt_dbus = i_dbus_cyc & (~i_ibus_cyc | ~last_dbus);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         last_dbus <= 1'b0;
      else if (state == IDLE && any_cyc)
         last_dbus <= gnt_dbus;
   end
`else
   assign gnt_dbus = i_dbus_cyc;
`endif

   // State and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
         req   <= '0;
         rdat  <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               cnt <= 3'd0;
               if (any_cyc) begin
                  if (gnt_dbus)
                     req <= '{adr: i_dbus_adr, we: i_dbus_we, dat: i_dbus_dat,
                              sel: i_dbus_sel, dbus: 1'b1};
                  else
                     req <= '{adr: i_ibus_adr, we: 1'b0, dat: 32'd0,
                              sel: 4'd0, dbus: 1'b0};
               end
            end
            RUN: begin
               cnt <= cnt + 3'd1;
               if (!req.we && cnt != 3'd0)
                  rdat[8*cap_i +: 8] <= i_ram_rdata;
            end
            default: ;
         endcase
      end
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_cyc) state_nxt = RUN;
         RUN:     if (run_done) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      o_ram_waddr = '0;
      o_ram_wdata = 8'd0;
      o_ram_wen   = 1'b0;
      o_ram_raddr = '0;
      o_ram_ren   = 1'b0;
      o_ibus_ack  = 1'b0;
      o_dbus_ack  = 1'b0;
      case (state)
         RUN: begin
            if (req.we) begin
               o_ram_waddr = {req.adr, byte_i};
               o_ram_wdata = req.dat[8*byte_i +: 8];
               o_ram_wen   = req.sel[byte_i];
            end else if (cnt != 3'd4) begin
               o_ram_raddr = {req.adr, byte_i};
               o_ram_ren   = 1'b1;
            end
         end
         ACK: begin
            o_dbus_ack = req.dbus;
            o_ibus_ack = ~req.dbus;
         end
         default: ;
      endcase
   end

   assign o_ibus_rdt = rdat;
   assign o_dbus_rdt = rdat;

endmodule

// File: tb/tb_serving_ram_arb.sv
// tb_serving_ram_arb
//   Directed bench for serving_ram_arb with a behavioural byte RAM
//   (registered read, preloaded bytes 0..7 = 11..88 hex, rest zero).
//   Expected order of arbitration depends on SERVING_RAM_ARB_RR_EN.
module tb_serving_ram_arb;

   localparam int DEPTH = 256;
   localparam int AW    = $clog2(DEPTH);

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [AW-3:0] i_ibus_adr = '0;
   logic          i_ibus_cyc = 1'b0;
   logic [31:0]   o_ibus_rdt;
   logic          o_ibus_ack;
   logic [AW-3:0] i_dbus_adr = '0;
   logic [31:0]   i_dbus_dat = 32'd0;
   logic [3:0]    i_dbus_sel = 4'd0;
   logic          i_dbus_we  = 1'b0;
   logic          i_dbus_cyc = 1'b0;
   logic [31:0]   o_dbus_rdt;
   logic          o_dbus_ack;
   logic [AW-1:0] o_ram_waddr;
   logic [7:0]    o_ram_wdata;
   logic          o_ram_wen;
   logic [AW-1:0] o_ram_raddr;
   logic          o_ram_ren;
   logic [7:0]    i_ram_rdata;

   logic          tb_load = 1'b1;
   logic [7:0]    mem [0:DEPTH-1];

   int errors = 0;
   int checks = 0;

   serving_ram_arb #(.depth(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
      .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
      .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
      .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
      .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
      .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata), .o_ram_wen(o_ram_wen),
      .o_ram_raddr(o_ram_raddr), .o_ram_ren(o_ram_ren), .i_ram_rdata(i_ram_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Behavioural RAM
   always @(posedge i_clk) begin
      if (tb_load) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= (i < 8) ? 8'(8'h11 * (i + 1)) : 8'h00;
      end else if (o_ram_wen) begin
         mem[o_ram_waddr] <= o_ram_wdata;
      end
      if (o_ram_ren)
         i_ram_rdata <= mem[o_ram_raddr];
   end

   task automatic test_reset();
      i_rst = 1'b1;
      tb_load = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if ({o_ibus_ack, o_dbus_ack} !== 2'b00) begin
         errors++; $display("FAIL reset_ack got=%b want=00", {o_ibus_ack, o_dbus_ack});
      end
      checks++;
      if ({o_ram_wen, o_ram_ren} !== 2'b00) begin
         errors++; $display("FAIL reset_en got=%b want=00", {o_ram_wen, o_ram_ren});
      end
      checks++;
      if ({o_ram_waddr, o_ram_raddr, o_ram_wdata} !== '0) begin
         errors++; $display("FAIL reset_addr got=%h/%h/%h want=0", o_ram_waddr, o_ram_raddr, o_ram_wdata);
      end
      checks++;
      if (o_ibus_rdt !== 32'd0 || o_dbus_rdt !== 32'd0) begin
         errors++; $display("FAIL reset_rdt got=%h/%h want=0", o_ibus_rdt, o_dbus_rdt);
      end
      i_rst = 1'b0;
      tb_load = 1'b0;
   endtask

   // ibus read of word 1: bytes 4..7, ack on cycle +6
   task automatic test_ibus_read();
      i_ibus_adr = 6'd1;
      i_ibus_cyc = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         @(posedge i_clk); #1;
         if (n <= 4) begin
            checks++;
            if (o_ram_ren !== 1'b1 || o_ram_raddr !== AW'(3 + n)) begin
               errors++; $display("FAIL ird_raddr n=%0d got ren=%b a=%0d want ren=1 a=%0d", n, o_ram_ren, o_ram_raddr, 3 + n);
            end
         end else begin
            checks++;
            if (o_ram_ren !== 1'b0) begin
               errors++; $display("FAIL ird_ren_off n=%0d got=%b want=0", n, o_ram_ren);
            end
         end
         checks++;
         if (o_ibus_ack !== (n == 6) || o_dbus_ack !== 1'b0 || o_ram_wen !== 1'b0) begin
            errors++; $display("FAIL ird_ack n=%0d got i=%b d=%b wen=%b want i=%b d=0 wen=0", n, o_ibus_ack, o_dbus_ack, o_ram_wen, n == 6);
         end
         if (n == 6) begin
            checks++;
            if (o_ibus_rdt !== 32'h88776655) begin
               errors++; $display("FAIL ird_rdt got=%h want=88776655", o_ibus_rdt);
            end
            i_ibus_cyc = 1'b0;
         end
      end
   endtask

   // dbus write 0xDEADBEEF sel=0101 to word 2, then read back
   task automatic test_dbus_write();
      logic [4:0] exp_wen;
      int lat;
      exp_wen = 5'b00101;  // n=1..5 -> bit n-1
      i_dbus_adr = 6'd2; i_dbus_dat = 32'hDEADBEEF; i_dbus_sel = 4'b0101;
      i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(posedge i_clk); #1;
         checks++;
         if (o_ram_wen !== exp_wen[n-1] || o_ram_ren !== 1'b0) begin
            errors++; $display("FAIL wr_wen n=%0d got=%b ren=%b want=%b", n, o_ram_wen, o_ram_ren, exp_wen[n-1]);
         end
         if (n == 1) begin
            checks++;
            if (o_ram_waddr !== 8'd8 || o_ram_wdata !== 8'hEF) begin
               errors++; $display("FAIL wr_b0 got a=%0d d=%h want a=8 d=ef", o_ram_waddr, o_ram_wdata);
            end
         end
         if (n == 3) begin
            checks++;
            if (o_ram_waddr !== 8'd10 || o_ram_wdata !== 8'hAD) begin
               errors++; $display("FAIL wr_b2 got a=%0d d=%h want a=10 d=ad", o_ram_waddr, o_ram_wdata);
            end
         end
         checks++;
         if (o_dbus_ack !== (n == 5) || o_ibus_ack !== 1'b0) begin
            errors++; $display("FAIL wr_ack n=%0d got d=%b i=%b want d=%b i=0", n, o_dbus_ack, o_ibus_ack, n == 5);
         end
      end
      i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
      @(posedge i_clk); #1;
      i_dbus_cyc = 1'b1;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge i_clk); #1;
         if (o_dbus_ack) begin lat = n; break; end
      end
      checks++;
      if (lat != 6) begin
         errors++; $display("FAIL wr_rdback_lat got=%0d want=6", lat);
      end
      checks++;
      if (o_dbus_rdt !== 32'h00AD00EF) begin
         errors++; $display("FAIL wr_rdback got=%h want=00ad00ef", o_dbus_rdt);
      end
      i_dbus_cyc = 1'b0;
      @(posedge i_clk); #1;
   endtask

   // sel=0000: full 4 RUN cycles, no write strobe, ack on +5
   task automatic test_sel_zero();
      int wen_seen, lat;
      wen_seen = 0; lat = 0;
      i_dbus_adr = 6'd3; i_dbus_dat = 32'hFFFFFFFF; i_dbus_sel = 4'b0000;
      i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(posedge i_clk); #1;
         if (o_ram_wen) wen_seen++;
         if (o_dbus_ack && lat == 0) begin lat = n; i_dbus_cyc = 1'b0; end
      end
      checks++;
      if (wen_seen != 0) begin
         errors++; $display("FAIL sel0_wen got=%0d strobes want=0", wen_seen);
      end
      checks++;
      if (lat != 5) begin
         errors++; $display("FAIL sel0_lat got=%0d want=5", lat);
      end
      checks++;
      if ({mem[12], mem[13], mem[14], mem[15]} !== 32'd0) begin
         errors++; $display("FAIL sel0_mem got=%h want=0", {mem[12], mem[13], mem[14], mem[15]});
      end
      i_dbus_we = 1'b0;
   endtask

   // Both buses request together for two reads each
   task automatic test_arbitration();
      int order [4];
      int exp_order [4];
      int k, d_left, i_left;
      logic [31:0] d_exp [2];
      logic [31:0] i_exp [2];
      d_exp[0] = 32'h44332211; d_exp[1] = 32'h88776655;
      i_exp[0] = 32'h88776655; i_exp[1] = 32'h44332211;
`ifdef SERVING_RAM_ARB_RR_EN
      exp_order = '{1, 0, 1, 0};
`else
      exp_order = '{1, 1, 0, 0};
`endif
      order = '{-1, -1, -1, -1};
      // fresh last-grant state
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      k = 0; d_left = 2; i_left = 2;
      i_dbus_we = 1'b0; i_dbus_adr = 6'd0; i_dbus_cyc = 1'b1;
      i_ibus_adr = 6'd1; i_ibus_cyc = 1'b1;
      for (int c = 0; c < 100 && (d_left + i_left) > 0; c++) begin
         @(posedge i_clk); #1;
         if (o_dbus_ack && d_left > 0) begin
            checks++;
            if (o_dbus_rdt !== d_exp[2-d_left]) begin
               errors++; $display("FAIL arb_drdt got=%h want=%h", o_dbus_rdt, d_exp[2-d_left]);
            end
            if (k < 4) order[k] = 1;
            k++; d_left--;
            if (d_left > 0) i_dbus_adr = 6'd1; else i_dbus_cyc = 1'b0;
         end
         if (o_ibus_ack && i_left > 0) begin
            checks++;
            if (o_ibus_rdt !== i_exp[2-i_left]) begin
               errors++; $display("FAIL arb_irdt got=%h want=%h", o_ibus_rdt, i_exp[2-i_left]);
            end
            if (k < 4) order[k] = 0;
            k++; i_left--;
            if (i_left > 0) i_ibus_adr = 6'd0; else i_ibus_cyc = 1'b0;
         end
      end
      checks++;
      if (d_left + i_left != 0) begin
         errors++; $display("FAIL arb_timeout got=%0d pending want=0", d_left + i_left);
      end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (order[j] != exp_order[j]) begin
            errors++; $display("FAIL arb_order slot=%0d got=%0d want=%0d (1=dbus)", j, order[j], exp_order[j]);
         end
      end
      i_dbus_cyc = 1'b0; i_ibus_cyc = 1'b0;
      @(posedge i_clk); #1;
   endtask

   // Reset sampled on the edge that would advance cnt to 1
   task automatic test_mid_reset();
      int ack_seen, lat;
      ack_seen = 0; lat = 0;
      i_dbus_adr = 6'd0; i_dbus_dat = 32'hA1B2C3D4; i_dbus_sel = 4'b1111;
      i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
      @(posedge i_clk); #1;
      checks++;
      if (o_ram_wen !== 1'b1 || o_ram_waddr !== 8'd0 || o_ram_wdata !== 8'hD4) begin
         errors++; $display("FAIL mrst_b0 got wen=%b a=%0d d=%h want 1/0/d4", o_ram_wen, o_ram_waddr, o_ram_wdata);
      end
      i_rst = 1'b1; i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      checks++;
      if ({o_ram_wen, o_ram_ren} !== 2'b00) begin
         errors++; $display("FAIL mrst_en got=%b want=00", {o_ram_wen, o_ram_ren});
      end
      for (int n = 0; n < 8; n++) begin
         if (o_dbus_ack || o_ibus_ack || o_ram_wen) ack_seen++;
         @(posedge i_clk); #1;
      end
      checks++;
      if (ack_seen != 0) begin
         errors++; $display("FAIL mrst_noack got=%0d want=0", ack_seen);
      end
      checks++;
      if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h443322D4) begin
         errors++; $display("FAIL mrst_mem got=%h want=443322d4", {mem[3], mem[2], mem[1], mem[0]});
      end
      // Arbiter must be back in IDLE and serve a fresh read normally
      i_ibus_adr = 6'd0; i_ibus_cyc = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge i_clk); #1;
         if (o_ibus_ack) begin lat = n; break; end
      end
      i_ibus_cyc = 1'b0;
      checks++;
      if (lat != 6 || o_ibus_rdt !== 32'h443322D4) begin
         errors++; $display("FAIL mrst_rd got lat=%0d rdt=%h want lat=6 rdt=443322d4", lat, o_ibus_rdt);
      end
   endtask

   initial begin
      test_reset();
      test_ibus_read();
      test_dbus_write();
      test_sel_zero();
      test_arbitration();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serving_ram_arb.md
Name: serving_ram_arb

Overview:
- Shares one byte-wide serving SRAM (8-bit data, 1-cycle registered read) between the CPU instruction bus and data bus.
- Each 32-bit Wishbone-classic word access is arbitrated, then sequenced as four byte accesses on the RAM port.
- Read bytes are assembled into a word and returned with a one-cycle ack.
- Sits between the CPU/bus mux and the RAM in the serving SoC.

Parameters:
- depth, 256: RAM size in bytes, power of two, >= 8.
- aw, $clog2(depth): RAM byte-address width. Word address width is aw-2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_ibus_adr  in  aw-2  ibus word address
- i_ibus_cyc  in  1  ibus request, held until ack
- o_ibus_rdt  out  32  ibus read data, valid only with o_ibus_ack
- o_ibus_ack  out  1  ibus ack, single-cycle pulse
- i_dbus_adr  in  aw-2  dbus word address
- i_dbus_dat  in  32  dbus write data
- i_dbus_sel  in  4  dbus byte enables, bit k = byte k
- i_dbus_we  in  1  dbus write when 1, read when 0
- i_dbus_cyc  in  1  dbus request, held until ack
- o_dbus_rdt  out  32  dbus read data, valid only with o_dbus_ack
- o_dbus_ack  out  1  dbus ack, single-cycle pulse
- o_ram_waddr  out  aw  RAM byte write address
- o_ram_wdata  out  8  RAM write byte
- o_ram_wen  out  1  RAM write enable
- o_ram_raddr  out  aw  RAM byte read address
- o_ram_ren  out  1  RAM read enable
- i_ram_rdata  in  8  RAM read byte, valid the cycle after the address is presented with ren

Behaviour:
- Reset: state IDLE, cnt 0, both acks 0, o_ram_wen/ren 0, RAM addresses/wdata 0, read-assembly register 0, last-grant flop = ibus.
- Reset mid-transfer aborts it: no ack issued, wen low from the next cycle; partially written bytes stay written.
- States:
  - IDLE: if any cyc is high, grant one requester. Latch adr/we/dat/sel (ibus: we=0). cnt<=0, go to RUN.
  - RUN, read: o_ram_ren=1 and o_ram_raddr={adr,cnt[1:0]} for cnt 0..3. For cnt 1..4, capture i_ram_rdata into byte cnt-1 of the assembly register. At cnt=4 issue nothing; go to ACK. RUN lasts 5 cycles.
  - RUN, write: for cnt 0..3, o_ram_waddr={adr,cnt}, o_ram_wdata=dat[8*cnt+:8], o_ram_wen=sel[cnt]. After cnt=3 go to ACK. RUN lasts 4 cycles.
  - ACK: the granted master's ack is 1 for exactly one cycle. Its rdt equals the assembled word (reads) or is don't-care (writes). The other master's ack stays 0. Go to IDLE.
- Latency from the IDLE cycle that samples cyc: read ack on cycle +6, write ack on cycle +5.
- Back-to-back: requester drops cyc the cycle after ack. IDLE re-samples cyc on the cycle after ACK, so there is at most one idle cycle between transfers.
- Write with sel=0000: runs the full 4 cycles with no RAM writes, then acks.
- Address wrap: byte index is always adr*4+0..3; never crosses a word boundary.
- Latched request fields are immune to requester input changes during RUN.
- No request is ever dropped; a losing requester waits in IDLE arbitration.
- Arbitration (default): dbus has fixed priority over ibus on simultaneous cyc.
- o_ram_ren=0 whenever not issuing a read; wen and ren are never both 1.

Optional Feature:
- Macro: SERVING_RAM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, grant the requester not granted last. The last-grant flop updates on every grant and resets to ibus, so the first tie goes to dbus.
- Undefined: fixed dbus priority as above; no last-grant flop is built.

Test Plan:
- RAM preloaded bytes 0..7 = 11,22,33,44,55,66,77,88; ibus read adr=1 -> RAM raddr 4,5,6,7 on consecutive cycles; o_ibus_ack on cycle +6 with o_ibus_rdt=0x88776655; o_dbus_ack stays 0.
- dbus write adr=2, dat=0xDEADBEEF, sel=0101 -> wen high only for byte addrs 8 (EF) and 10 (AD); ack on cycle +5; follow-up read of adr 2 returns 0x00AD00EF (RAM zero-init).
- ibus and dbus cyc both asserted in the same cycle, repeatedly for 4 transfers, macro undefined -> all dbus transfers are served before any ibus transfer.
- Same stimulus with SERVING_RAM_ARB_RR_EN -> grants alternate dbus, ibus, dbus, ibus.
- i_rst pulsed during write RUN at cnt=1 (sel=1111) -> only byte 0 written, no ack, wen=0 from the next cycle, state IDLE.
- dbus write with sel=0000 -> o_ram_wen never asserted; ack on cycle +5; RAM contents unchanged.
